// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC, one-cycle imem handshake and stall-tolerant fetch FIFO with redirect flush
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        ifid_stall,
  output logic        out_valid,
  output logic [15:0] out_inst,
  output logic [15:0] out_pc_added
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            LAST_I  = DEPTH - 1;
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW-1:0] LAST    = LAST_I[AW-1:0];

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   inflight_pc_q, inflight_pc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   inst_q [DEPTH];
  logic [15:0]   pc_q   [DEPTH];
  logic [AW:0]   occ;
  logic          push, pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // An in-flight request has a reserved slot, so issue only while entries plus outstanding fit
  assign occ       = count_q + {{AW{1'b0}}, inflight_q};
  assign imem_req  = !rst && !redirect && (occ < DEPTH_C);
  assign imem_addr = fetch_pc_q;
  assign push      = inflight_q && !redirect;
  assign pop       = out_valid && !ifid_stall && !redirect;

  // Outputs come only from registered FIFO state, never from imem_rdata directly
  assign out_valid    = (count_q != '0);
  assign out_inst     = out_valid ? inst_q[rd_q] : NOP_INST;
  assign out_pc_added = out_valid ? pc_q[rd_q] : 16'h0000;

  // Next-state: redirect flushes everything and restarts at the target
  always_comb begin
    fetch_pc_d    = redirect ? redirect_target : imem_req ? fetch_pc_q + 16'd1 : fetch_pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = imem_req ? fetch_pc_q : inflight_pc_q;
    wr_d          = redirect ? '0 : push ? inc(wr_q) : wr_q;
    rd_d          = redirect ? '0 : pop ? inc(rd_q) : rd_q;
    count_d       = redirect ? '0 : count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Control state registers; reset wins over redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= 16'h0000;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
      rd_q          <= '0;
      wr_q          <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      count_q       <= count_d;
    end
  end

  // FIFO payload storage; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_q[wr_q] <= imem_rdata;
      pc_q[wr_q]   <= inflight_pc_q + 16'd1;
    end
  end
endmodule
